// File: rtl/register_file.sv
// 16 x 32-bit general register file: one synchronous write port, three combinational read ports.
// Optional macro WRITE_BYPASS_EN forwards PW to any read port whose select matches RW while E=1.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] PW,
  input  logic [ADDR_W-1:0] RW,
  input  logic              E,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PC
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   wr_sel_d;

  // One-hot write decoder; all-zero when the write port is idle.
  always_comb begin
    wr_sel_d     = '0;
    wr_sel_d[RW] = E;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_sel_d[i]) regs_q[i] <= PW;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
`ifdef WRITE_BYPASS_EN
    // Forwarding is suppressed during reset so held-reset reads stay zero.
    if (RST_N && E && (sel == RW)) return PW;
    else return regs_q[sel];
`else
    return regs_q[sel];
`endif
  endfunction

  assign PA = read_port(RA);
  assign PB = read_port(RB);
  assign PC = read_port(RC);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array-based model checked every cycle plus directed literals.
module tb_register_file;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PW;
  logic [3:0]  RW;
  logic        E;
  logic [3:0]  RA, RB, RC;
  logic [31:0] PA, PB, PC;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] mdl [16];

  register_file #(.DATA_W(32), .ADDR_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .PW(PW), .RW(RW), .E(E),
    .RA(RA), .RB(RB), .RC(RC), .PA(PA), .PB(PB), .PC(PC)
  );

  always #5 CLK = ~CLK;

  // Model: registers are an array; reset clears it, a posedge with E writes one entry.
  always @(negedge RST_N) for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  always @(posedge CLK) if (RST_N === 1'b1 && E === 1'b1) mdl[RW] = PW;

  function automatic logic [31:0] exp_rd(input logic [3:0] sel);
`ifdef WRITE_BYPASS_EN
    if (RST_N && E && sel == RW) return PW;
`endif
    return mdl[sel];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compare process: every falling edge, all three ports against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_PA", PA, exp_rd(RA));
      chk("model_PB", PB, exp_rd(RB));
      chk("model_PC", PC, exp_rd(RC));
    end
  end

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    RW = a; PW = d; E = 1'b1;
    after_edge();
    E = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    RST_N = 1'b0; PW = '0; RW = '0; E = 1'b0; RA = '0; RB = '0; RC = '0;
    #1;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    cmp_en = 1'b1;

    // 1: reset held, sweep all selects
    for (int i = 0; i < 16; i++) begin
      RA = 4'(i); RB = 4'(15 - i); RC = 4'(i);
      #1;
      chk("rst_PA", PA, 32'h0);
      chk("rst_PB", PB, 32'h0);
      chk("rst_PC", PC, 32'h0);
      after_edge();
    end
    RST_N = 1'b1;
    after_edge();

    // 2
    wr(4'd5, 32'hAABBCCDD);
    RA = 4'd5; RB = 4'd4; RC = 4'd6; #1;
    chk("t2_PA", PA, 32'hAABBCCDD);
    chk("t2_PB_other", PB, 32'h0);
    chk("t2_PC_other", PC, 32'h0);

    // 3
    wr(4'd10, 32'h11223344);
    RA = 4'd5; RB = 4'd10; #1;
    chk("t3_PA", PA, 32'hAABBCCDD);
    chk("t3_PB", PB, 32'h11223344);

    // 4
    wr(4'd15, 32'hFFFFFFFF);
    RC = 4'd15; #1;
    chk("t4_PC", PC, 32'hFFFFFFFF);
    RW = 4'd15; PW = 32'h12345678; E = 1'b0;
    after_edge();
    chk("t4_PC_noE", PC, 32'hFFFFFFFF);

    // 5: same register on all ports, read-during-write
    RA = 4'd10; RB = 4'd10; RC = 4'd10; #1;
    chk("t5_PA", PA, 32'h11223344);
    chk("t5_PB", PB, 32'h11223344);
    chk("t5_PC", PC, 32'h11223344);
    RW = 4'd10; PW = 32'hDEADBEEF; E = 1'b1; #1;
`ifdef WRITE_BYPASS_EN
    v = 32'hDEADBEEF;
`else
    v = 32'h11223344;
`endif
    chk("t5_rdw_PA", PA, v);
    chk("t5_rdw_PC", PC, v);
    after_edge();
    E = 1'b0; #1;
    chk("t5_post_PB", PB, 32'hDEADBEEF);

    // Fill every register, including R0 and R15, then read back
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hA5A50000 | 32'(i * 17));
    for (int i = 0; i < 16; i++) begin
      RA = 4'(i); RB = 4'(i ^ 3); RC = 4'(i); #1;
      chk("fill_PA", PA, 32'hA5A50000 | 32'(i * 17));
      chk("fill_PB", PB, 32'hA5A50000 | 32'((i ^ 3) * 17));
      after_edge();
    end

    // 6: async reset between edges, with a write pending across an edge
    RA = 4'd3; RB = 4'd0; RC = 4'd15;
    RW = 4'd3; PW = 32'hCAFEF00D; E = 1'b1;
    #1;
    RST_N = 1'b0; #1;
    chk("t6_async_PA", PA, 32'h0);
    chk("t6_async_PB", PB, 32'h0);
    chk("t6_async_PC", PC, 32'h0);
    after_edge();
    E = 1'b0; RST_N = 1'b1; #1;
    chk("t6_lost_write", PA, 32'h0);
    wr(4'd0, 32'h1);
    RA = 4'd0; #1;
    chk("t6_R0", PA, 32'h1);

    // Changes to write inputs between edges have no effect when dropped before the edge
    RW = 4'd7; PW = 32'h77777777; E = 1'b1; #1;
    E = 1'b0;
    after_edge();
    RB = 4'd7; #1;
    chk("glitch_write", PB, 32'h0);

    after_edge();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
